// File: rtl/mips_pkg.sv
// Shared MIPS-Lite definitions used by the EX-stage multiplier and its consumers.
//   mul_state_t : multiplier sequencer states
//   MUL_ITER    : shift-add iterations per product
//   MUL_LATENCY : cycles from start-sampling cycle to done (hazard unit / benches)
//   mag32       : two's complement magnitude of a 32-bit operand when signed
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } mul_state_t;

    localparam int unsigned MUL_ITER    = 32;
    localparam int unsigned MUL_LATENCY = 34;

    // 0x80000000 maps onto itself, which read unsigned is exactly 2^31.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mul_seq.sv
// Iterative radix-2 shift-add 32x32 multiplier for the EX stage.
// Operands are reduced to magnitudes on start, multiplied unsigned over 32
// iterations, then the sign is applied to the full 64-bit product.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   start      begin a multiply (sampled in IDLE only)
//   is_signed  1 = MULT, 0 = MULTU (sampled with start)
//   a, b       multiplicand / multiplier (sampled with start)
//   abort      cancel an in-flight operation (RUN or FIX)
//   busy       operation in flight, used to stall the pipeline
//   done       one-cycle pulse when hi/lo have just been updated
//   hi, lo     upper / lower product word, held until next completion
module mul_seq
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [5:0] LAST_ITER = 6'(MUL_ITER - 1);

    mul_state_t  state_q, state_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [63:0] acc_q, acc_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [32:0] sum;
    logic [63:0] product;

    // Carry-out is kept so it shifts into acc[63] rather than being lost.
    assign sum     = {1'b0, acc_q[63:32]} + {1'b0, (mplier_q[0] ? mcand_q : 32'd0)};
    assign product = neg_q ? (~acc_q + 64'd1) : acc_q;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = mag32(a, is_signed);
                    mplier_d = mag32(b, is_signed);
                    neg_d    = is_signed & (a[31] ^ b[31]);
                    acc_d    = 64'd0;
                    cnt_d    = 6'd0;
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    // Shifted-out multiplier bits are not needed; product bits
                    // accumulate into the lower half of acc instead.
                    acc_d    = {sum, acc_q[31:1]};
                    mplier_d = {1'b0, mplier_q[31:1]};
                    cnt_d    = cnt_q + 6'd1;
                    if (cnt_q == LAST_ITER) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                busy_d  = 1'b0;
                state_d = IDLE;
                // abort wins over completion: results are discarded.
                if (!abort) begin
                    hi_d   = product[63:32];
                    lo_d   = product[31:0];
                    done_d = 1'b1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            mcand_q  <= 32'd0;
            mplier_q <= 32'd0;
            acc_q    <= 64'd0;
            cnt_q    <= 6'd0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_seq.sv
// Directed self-checking bench for mul_seq. Inputs change and outputs are
// sampled on the falling edge.
module tb_mul_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        abort;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks;
    int n_pass;

    mul_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the sampling edge.
    task automatic start_op(input logic sgn, input logic [31:0] op_a, input logic [31:0] op_b);
        start     = 1'b1;
        is_signed = sgn;
        a         = op_a;
        b         = op_b;
        @(negedge clk);
        start     = 1'b0;
        a         = 32'hDEAD_BEEF;
        b         = 32'hCAFE_F00D;
    endtask

    // skip = falling edges already spent since start_op returned.
    task automatic wait_done(input string tag, input int skip, input logic [31:0] exp_hi,
                             input logic [31:0] exp_lo);
        int n;
        int busy_cnt;
        n        = 0;
        busy_cnt = 0;
        while (!done && n < 60) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            n++;
        end
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " latency"}, 64'(n + skip + 1), 64'(34));
        check({tag, " busy cycles"}, 64'(busy_cnt + skip), 64'(33));
        check({tag, " busy at done"}, 64'(busy), 64'd0);
        check({tag, " hi"}, 64'(hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(lo), 64'(exp_lo));
    endtask

    task automatic run_op(input string tag, input logic sgn, input logic [31:0] op_a,
                          input logic [31:0] op_b, input logic [63:0] exp);
        @(negedge clk);
        start_op(sgn, op_a, op_b);
        wait_done(tag, 0, exp[63:32], exp[31:0]);
        @(negedge clk);
        check({tag, " done pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int seen;
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        a         = 32'd0;
        b         = 32'd0;
        abort     = 1'b0;

        repeat (2) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hilo", {hi, lo}, 64'd0);
        rst = 1'b1;

        // abort in IDLE does nothing
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("idle abort busy", 64'(busy), 64'd0);

        run_op("u 7x6", 1'b0, 32'd7, 32'd6, 64'h0000_0000_0000_002A);
        run_op("u max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_op("s -3x5", 1'b1, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op("u -3x5", 1'b0, 32'hFFFF_FFFD, 32'd5, 64'h0000_0004_FFFF_FFF1);
        run_op("s min*min", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        run_op("s min*1", 1'b1, 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000);
        run_op("s -1*-1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);

        // start re-pulsed during RUN is ignored
        @(negedge clk);
        start_op(1'b0, 32'h1234_5678, 32'h0000_0010);
        repeat (5) @(negedge clk);
        start_op(1'b1, 32'd7, 32'd6);
        wait_done("repulse", 6, 32'h0000_0001, 32'h2345_6780);

        // back-to-back: second start issued on the done cycle
        @(negedge clk);
        start_op(1'b0, 32'h0001_0000, 32'h0001_0000);
        wait_done("b2b first", 0, 32'h0000_0001, 32'h0000_0000);
        start_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("b2b done drop", 64'(done), 64'd0);
        check("b2b busy", 64'(busy), 64'd1);
        wait_done("b2b second", 0, 32'h0000_0000, 32'h0000_0001);

        // abort at iteration 10: no done, previous result held
        @(negedge clk);
        start_op(1'b0, 32'd100, 32'd200);
        repeat (10) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        seen = 0;
        repeat (40) begin
            if (done) seen++;
            @(negedge clk);
        end
        check("abort no done", 64'(seen), 64'd0);
        check("abort hilo kept", {hi, lo}, 64'h0000_0000_0000_0001);

        // abort on the FIX cycle beats completion
        start_op(1'b0, 32'd9, 32'd9);
        repeat (32) @(negedge clk);
        check("fix abort busy before", 64'(busy), 64'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("fix abort done", 64'(done), 64'd0);
        check("fix abort busy", 64'(busy), 64'd0);
        check("fix abort hilo kept", {hi, lo}, 64'h0000_0000_0000_0001);

        // reset mid-RUN clears outputs
        @(negedge clk);
        start_op(1'b0, 32'd5, 32'd5);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid rst busy", 64'(busy), 64'd0);
        check("mid rst done", 64'(done), 64'd0);
        check("mid rst hilo", {hi, lo}, 64'd0);
        rst = 1'b1;

        run_op("after rst 3x4", 1'b0, 32'd3, 32'd4, 64'h0000_0000_0000_000C);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
